adder_block_accumulator: RTL and testbench
==========================================

# adder_block_accumulator

Downstream consumer of the registered 5-bit signed adder output. Accepts one signed sum per valid/ready transfer and accumulates a fixed-length block of `BLOCK_LEN` sums. It then presents the block total on a registered valid/ready output port, with saturation and a sticky overflow flag. It is the next stage after the adder, turning per-cycle sums into block totals for the downstream checker/consumer.

## Interface
Parameters:
- `IN_W`, 5: width of the incoming signed sum (adder output width).
- `ACC_W`, 8: width of the signed accumulator and result.
- `BLOCK_LEN`, 16: number of samples per block. Legal range is 1..255.

Ports:
- `clk`  input  1: single clock, all logic on the rising edge.
- `reset`  input  1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `in_valid`  input  1: `in_sum` is valid.
- `in_ready`  output  1: the block can accept a sample.
- `in_sum`  input  IN_W, signed: sum from the adder stage.
- `out_valid`  output  1: block result is valid.
- `out_ready`  input  1: consumer accepts the result.
- `out_acc`  output  ACC_W, signed: block total.
- `out_count`  output  8: samples accepted in the current block.
- `out_ovf`  output  1: sticky flag, set if any accumulation step in the block overflowed ACC_W.

## Operation
- The FSM has three states: IDLE, ACCUM and HOLD.
- **IDLE**
  - `in_ready`=1 and the accumulator is 0.
  - On an accept (`in_valid`&&`in_ready` at an edge), go to ACCUM.
  - If `BLOCK_LEN`=1, go directly to HOLD instead.
- **ACCUM**
  - Every accept adds `in_sum` to the accumulator and increments the count.
  - The accept that makes count==`BLOCK_LEN` moves the FSM to HOLD.
- **HOLD**
  - `in_ready`=0 and `out_valid`=1. `out_acc`, `out_count` and `out_ovf` are frozen.
  - An edge with `out_ready`=1 completes the handoff and returns to IDLE.
  - On that handoff the accumulator, count and `out_ovf` are cleared.
- **Arithmetic**
  - Sign-extend `in_sum` to ACC_W+1 bits and add it to the sign-extended accumulator.
  - Overflow means the result is outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On overflow, `out_ovf` is set and stays set until the handoff. The result written back is defined under Configuration.
- **Input gating:** `in_sum` is ignored whenever `in_valid`=0 or `in_ready`=0. Gaps in `in_valid` do not reset the block.
- **Live outputs:** `out_acc` and `out_count` show the running total and count in IDLE and ACCUM as well, but they are only meaningful while `out_valid`=1.
- **Reset (`reset`=0 at an edge), in any state including mid-block or HOLD:**
  - State goes to IDLE.
  - `out_acc`=0, `out_count`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=1.
  - No partial result is emitted.

## Timing
- All outputs are registered. `in_ready` is decoded from registered state only and has no combinational path from `out_ready`.
- Latency: `out_valid` rises on the edge that accepts the `BLOCK_LEN`-th sample. It is visible in the cycle following that edge.
- `out_valid` falls on the edge where `out_ready`=1 in HOLD. `in_ready` rises on the same edge.
  - The earliest accept of the next block's first sample is the edge after the handoff.
  - There is a one-cycle bubble per block.
- `out_ready` asserted while not in HOLD has no effect.
- Throughput is one sample per cycle in IDLE and ACCUM.

## Configuration
- Macro: `ADDER_ACC_SATURATE_EN`.
- **Defined:** on overflow the accumulator is clamped to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Further samples continue from the clamped value.
- **Undefined:** on overflow the accumulator wraps; the low ACC_W bits of the result are kept.
- `out_ovf` behaves identically in both builds.

## Structure
- Package `adder_acc_pkg` holds:
  - `acc_state_e` (IDLE, ACCUM, HOLD).
  - Default constants `ADDER_SUM_W`=5, `ACC_W_DEF`=8, `BLOCK_LEN_DEF`=16.
  - Function `acc_limit_max/min(ACC_W)`.
- Sub-module `acc_sat_add`: a combinational ACC_W adder with an IN_W sign-extended operand. Outputs are the result and the overflow flag. The `ADDER_ACC_SATURATE_EN` guard lives inside this sub-module only.
- The top level contains the FSM, counter, registers and handshake logic.

## Test plan
All scenarios use default parameters.
1. **Reset:** hold `reset`=0 for 2 edges with `in_valid`=1 → `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0, `in_ready`=1, and no sample is counted.
2. **Nominal block:** 16 back-to-back samples of +3 with `out_ready`=1 → `out_valid` high for exactly 1 cycle after the 16th accept, with `out_acc`=48, `out_count`=16, `out_ovf`=0.
3. **Positive overflow:** 16 samples of +15 (raw total 240) → with the macro, `out_acc`=127 and `out_ovf`=1; without the macro, `out_acc`=-16 and `out_ovf`=1.
4. **Negative overflow:** 16 samples of -16 (raw total -256) → with the macro, `out_acc`=-128 and `out_ovf`=1; without the macro, `out_acc`=0 and `out_ovf`=1.
5. **Backpressure:** `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1 with `in_sum`=+7 → `out_valid` and `out_acc` remain stable and `in_ready`=0. After `out_ready`=1, the next block of 16×(+1) yields 16, confirming no stray sample was captured.
6. **Reset mid-block:** assert `reset`=0 after 7 samples of +5 → the next cycle shows `out_count`=0 and `out_acc`=0. A following 16×(-2) block yields `out_acc`=-32 and `out_ovf`=0.

Source files
------------

// File: rtl/adder_block_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// adder_acc_pkg
// Shared types and constants for the adder block accumulator.
//   acc_state_e      : FSM state encoding (IDLE, ACCUM, HOLD)
//   ADDER_SUM_W      : default width of the incoming adder sum
//   ACC_W_DEF        : default accumulator width
//   BLOCK_LEN_DEF    : default number of samples per block
//   acc_limit_max/min: signed range limits of an acc_w-bit accumulator
// ---------------------------------------------------------------------------
package adder_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  localparam int ADDER_SUM_W   = 5;
  localparam int ACC_W_DEF     = 8;
  localparam int BLOCK_LEN_DEF = 16;

  // Valid for acc_w up to 31.
  function automatic int acc_limit_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int acc_limit_min(input int acc_w);
    return -(1 << (acc_w - 1));
  endfunction

endpackage

// File: rtl/adder_block_accumulator_if.sv
// ---------------------------------------------------------------------------
// adder_block_accumulator_if
// Sample input and block-result output handshakes of the accumulator.
//   in_valid / in_ready / in_sum     : one signed sum per transfer
//   out_valid / out_ready            : block result handshake
//   out_acc / out_count / out_ovf    : block total, sample count, sticky ovf
// Modports: master = producer/consumer side, slave = accumulator side.
// ---------------------------------------------------------------------------
interface adder_block_accumulator_if
  import adder_acc_pkg::*;
#(
  parameter int IN_W  = ADDER_SUM_W,
  parameter int ACC_W = ACC_W_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic [7:0]              out_count;
  logic                    out_ovf;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/adder_block_accumulator_acc_sat_add.sv
// ---------------------------------------------------------------------------
// acc_sat_add
// Combinational ACC_W-bit signed adder with a sign-extended IN_W operand.
//   acc    : current accumulator value
//   addend : incoming signed sample
//   result : value to write back (wrapped, or clamped when saturating)
//   ovf    : sum fell outside the signed ACC_W range
// Build option: define ADDER_ACC_SATURATE_EN to clamp on overflow instead of
// wrapping. Requires IN_W <= ACC_W.
// ---------------------------------------------------------------------------
module acc_sat_add
  import adder_acc_pkg::*;
#(
  parameter int IN_W  = ADDER_SUM_W,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [IN_W-1:0]  addend,
  output logic signed [ACC_W-1:0] result,
  output logic                    ovf
);

  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] add_x;
  logic signed [ACC_W:0] wide;

  // One guard bit is enough: the sum of two ACC_W-range values fits ACC_W+1.
  assign acc_x = {acc[ACC_W-1], acc};
  assign add_x = {{(ACC_W + 1 - IN_W){addend[IN_W-1]}}, addend};
  assign wide  = acc_x + add_x;

  // Result is out of range exactly when the guard bit and the MSB disagree.
  assign ovf = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef ADDER_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(acc_limit_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(acc_limit_min(ACC_W));

  // The guard bit carries the true sign, so it picks the clamp direction.
  always_comb begin
    result = wide[ACC_W-1:0];
    if (ovf) result = wide[ACC_W] ? MIN_V : MAX_V;
  end
`else
  assign result = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/adder_block_accumulator.sv
// ---------------------------------------------------------------------------
// adder_block_accumulator
// Accumulates BLOCK_LEN signed sums and presents the block total on a
// registered valid/ready port with a sticky overflow flag.
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : adder_block_accumulator_if.slave (input and result handshakes)
// Build option: ADDER_ACC_SATURATE_EN selects clamping over wrapping in
// the acc_sat_add sub-module.
// ---------------------------------------------------------------------------
module adder_block_accumulator
  import adder_acc_pkg::*;
#(
  parameter int IN_W      = ADDER_SUM_W,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input logic                       clk,
  input logic                       reset,
  adder_block_accumulator_if.slave  bus
);

  localparam logic [7:0] BLOCK_LEN_C = 8'(BLOCK_LEN);

  acc_state_e              state_q,     state_d;
  logic signed [ACC_W-1:0] acc_q,       acc_d;
  logic [7:0]              count_q,     count_d;
  logic                    ovf_q,       ovf_d;
  logic                    in_ready_q,  in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0] sum_res;
  logic                    sum_ovf;
  logic                    accept;
  logic [7:0]              count_inc;

  acc_sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (acc_q),
    .addend (bus.in_sum),
    .result (sum_res),
    .ovf    (sum_ovf)
  );

  assign accept    = bus.in_valid && in_ready_q;
  assign count_inc = count_q + 8'd1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      // IDLE and ACCUM share the accept path: in IDLE count and acc are zero,
      // so the BLOCK_LEN==1 case falls out of the same compare.
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = sum_res;
          count_d = count_inc;
          ovf_d   = ovf_q | sum_ovf;
          state_d = (count_inc == BLOCK_LEN_C) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so in_ready never
  // sees a combinational path from out_ready.
  assign in_ready_d  = (state_d != HOLD);
  assign out_valid_d = (state_d == HOLD);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; the reset is
    // synchronous, so it is just the first branch inside the clocked block.
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_block_accumulator.sv
// ---------------------------------------------------------------------------
// tb_adder_block_accumulator
// Self-checking bench for adder_block_accumulator with default parameters.
// Expected block totals come from an integer model of the block arithmetic;
// build with ADDER_ACC_SATURATE_EN to check the clamping variant.
// ---------------------------------------------------------------------------
module tb_adder_block_accumulator;
  import adder_acc_pkg::*;

  localparam int IN_W      = ADDER_SUM_W;
  localparam int ACC_W     = ACC_W_DEF;
  localparam int BLOCK_LEN = BLOCK_LEN_DEF;
  localparam int LIM_MAX   = (1 << (ACC_W - 1)) - 1;
  localparam int LIM_MIN   = -(1 << (ACC_W - 1));

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  adder_block_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  adder_block_accumulator #(
    .IN_W      (IN_W),
    .ACC_W     (ACC_W),
    .BLOCK_LEN (BLOCK_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int samples[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Block total from the arithmetic rules: exact integer sum per step, then
  // wrap or clamp into the signed ACC_W range when it leaves it.
  function automatic void model(output int acc, output bit ovf);
    int raw;
    acc = 0;
    ovf = 1'b0;
    foreach (samples[i]) begin
      raw = acc + samples[i];
      if (raw > LIM_MAX || raw < LIM_MIN) begin
        ovf = 1'b1;
`ifdef ADDER_ACC_SATURATE_EN
        acc = (raw > LIM_MAX) ? LIM_MAX : LIM_MIN;
`else
        acc = (raw > LIM_MAX) ? raw - (1 << ACC_W) : raw + (1 << ACC_W);
`endif
      end else begin
        acc = raw;
      end
    end
  endfunction

  // Feeds the queued samples, holds the result for hold_cycles, then hands
  // it off and checks the return to an empty IDLE block.
  task automatic run_block(input string name, input int hold_cycles,
                           input bit gaps, input bit ready_early);
    int exp_acc;
    bit exp_ovf;
    int idx    = 0;
    int budget = 0;
    logic [ACC_W-1:0] held_acc;
    bit v;
    model(exp_acc, exp_ovf);
    bus.out_ready = ready_early;
    while (idx < samples.size() && budget < 400) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_sum   = v ? IN_W'(samples[idx]) : IN_W'($urandom);
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s in_ready_feed: got %b want 1", name, bus.in_ready);
      end
      tick();
      budget++;
      if (v) idx++;
      if (idx < samples.size()) begin
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_count !== 8'(idx)) begin
          n_fail++;
          $display("FAIL %s live_count: got valid=%b count=%0d want valid=0 count=%0d",
                   name, bus.out_valid, bus.out_count, idx);
        end
      end
    end
    if (budget >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s feed_timeout: got %0d accepts want %0d", name, idx, samples.size());
    end

    // Stray input while the result is held must be ignored.
    bus.in_valid  = 1'b1;
    bus.in_sum    = IN_W'(7);
    bus.out_ready = (hold_cycles == 0);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.out_acc !== ACC_W'(exp_acc) || bus.out_count !== 8'(BLOCK_LEN) ||
        bus.out_ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s result: got valid=%b rdy=%b acc=%0d cnt=%0d ovf=%b want 1 0 %0d %0d %b",
               name, bus.out_valid, bus.in_ready, $signed(bus.out_acc), bus.out_count,
               bus.out_ovf, exp_acc, BLOCK_LEN, exp_ovf);
    end
    held_acc = bus.out_acc;
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_acc !== held_acc ||
          bus.out_count !== 8'(BLOCK_LEN) || bus.out_ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL %s hold[%0d]: got valid=%b rdy=%b acc=%0d cnt=%0d want 1 0 %0d %0d",
                 name, i, bus.out_valid, bus.in_ready, $signed(bus.out_acc),
                 bus.out_count, exp_acc, BLOCK_LEN);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_acc !== '0 ||
        bus.out_count !== 8'd0 || bus.out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handoff: got valid=%b rdy=%b acc=%0d cnt=%0d ovf=%b want 0 1 0 0 0",
               name, bus.out_valid, bus.in_ready, $signed(bus.out_acc), bus.out_count,
               bus.out_ovf);
    end
  endtask

  task automatic fill(input int value, input int n);
    samples = {};
    for (int i = 0; i < n; i++) samples.push_back(value);
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sum    = IN_W'(5);
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_acc !== '0 ||
        bus.out_count !== 8'd0 || bus.out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b rdy=%b acc=%0d cnt=%0d ovf=%b want 0 1 0 0 0",
               bus.out_valid, bus.in_ready, $signed(bus.out_acc), bus.out_count, bus.out_ovf);
    end
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    n_tests++;
    if (bus.out_count !== 8'd0 || bus.out_acc !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got cnt=%0d acc=%0d want 0 0",
               bus.out_count, $signed(bus.out_acc));
    end
  endtask

  task automatic test_nominal();
    fill(3, BLOCK_LEN);
    run_block("nominal", 0, 1'b0, 1'b1);
  endtask

  task automatic test_pos_overflow();
    fill(15, BLOCK_LEN);
    run_block("pos_ovf", 1, 1'b0, 1'b0);
  endtask

  task automatic test_neg_overflow();
    fill(-16, BLOCK_LEN);
    run_block("neg_ovf", 2, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill(4, BLOCK_LEN);
    run_block("backpressure", 5, 1'b0, 1'b0);
    fill(1, BLOCK_LEN);
    run_block("after_backpressure", 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_block();
    bus.in_sum = IN_W'(5);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      tick();
    end
    n_tests++;
    if (bus.out_count !== 8'd7 || bus.out_acc !== ACC_W'(35)) begin
      n_fail++;
      $display("FAIL mid_block_partial: got cnt=%0d acc=%0d want 7 35",
               bus.out_count, $signed(bus.out_acc));
    end
    reset = 1'b0;
    tick();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_count !== 8'd0 || bus.out_acc !== '0 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_block_reset: got cnt=%0d acc=%0d valid=%b rdy=%b ovf=%b want 0 0 0 1 0",
               bus.out_count, $signed(bus.out_acc), bus.out_valid, bus.in_ready, bus.out_ovf);
    end
    fill(-2, BLOCK_LEN);
    run_block("after_mid_reset", 1, 1'b0, 1'b0);
  endtask

  task automatic test_random_blocks();
    for (int b = 0; b < 8; b++) begin
      samples = {};
      for (int i = 0; i < BLOCK_LEN; i++)
        samples.push_back($urandom_range(0, 31) - 16);
      run_block($sformatf("random%0d", b), $urandom_range(0, 4), 1'b1,
                1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      samples = {};
      for (int i = 0; i < BLOCK_LEN; i++)
        samples.push_back($urandom_range(0, 1) ? 15 : -16);
      run_block($sformatf("b2b%0d", b), 0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_pos_overflow();
    test_neg_overflow();
    test_backpressure();
    test_reset_mid_block();
    test_random_blocks();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
